// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FS_REQ   = 2'd0,
    FS_WAIT  = 2'd1,
    FS_DRAIN = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Owns the PC, issues one imem read at a time and holds the returned word
// in a one-entry instruction register; squashes on redirect, faults on misalignment.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        fetch_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         iv_q, iv_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic [31:0]  ipc4_q, ipc4_d;
  logic         fault_q, fault_d;

  logic consume;
  logic handshake;
  logic redirect_bad;

  // A request is only offered when the IR has room, so a response never finds it full.
  assign imem_req_valid = (state_q == FS_REQ) && (!iv_q || !stall);
  assign imem_req_addr  = pc_q;

  assign consume      = iv_q && !stall;
  assign handshake    = imem_req_valid && imem_req_ready;
  assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iv_d    = iv_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    fault_d = fault_q;

    if (state_q == FS_FAULT) begin
      fault_d = 1'b1;
    end else if (redirect_bad) begin
      state_d = FS_FAULT;
      iv_d    = 1'b0;
      fault_d = 1'b1;
    end else if (redirect_valid) begin
      // Any accepted-but-unanswered request must have its response discarded.
      pc_d = redirect_target;
      iv_d = 1'b0;
      case (state_q)
        FS_REQ:   state_d = handshake ? FS_DRAIN : FS_REQ;
        FS_WAIT,
        FS_DRAIN: state_d = imem_rsp_valid ? FS_REQ : FS_DRAIN;
        default:  state_d = state_q;
      endcase
    end else begin
      if (consume) begin
        iv_d = 1'b0;
      end
      case (state_q)
        FS_REQ: begin
          if (handshake) begin
            state_d = FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (imem_rsp_valid) begin
            instr_d = imem_rsp_data;
            ipc_d   = pc_q;
            ipc4_d  = pc_next(pc_q);
            iv_d    = 1'b1;
            pc_d    = pc_next(pc_q);
            state_d = FS_REQ;
          end
        end
        FS_DRAIN: begin
          if (imem_rsp_valid) begin
            state_d = FS_REQ;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_REQ;
      pc_q    <= RESET_PC;
      iv_q    <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      ipc4_q  <= 32'h0000_0004;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iv_q    <= iv_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      fault_q <= fault_d;
    end
  end

  assign instr_valid    = iv_q;
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign instr_pc_plus4 = ipc4_q;
  assign fetch_fault    = fault_q;

endmodule
